// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the sequential square-root block.
// SQRT_ROUND_EN adds one guard iteration used for round-half-up results.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int sqrt_out_w(input int in_w, input int frac_w);
        return (in_w + 1) / 2 + frac_w;
    endfunction

    function automatic int sqrt_iter(input int in_w, input int frac_w);
`ifdef SQRT_ROUND_EN
        return sqrt_out_w(in_w, frac_w) + 1;
`else
        return sqrt_out_w(in_w, frac_w);
`endif
    endfunction

    // Holds ITER-1 down to 0; never narrower than one bit.
    function automatic int sqrt_cnt_w(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

    localparam int DEF_IN_W   = 8;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_ITER   = sqrt_iter(DEF_IN_W, DEF_FRAC_W);
    localparam int DEF_CNT_W  = sqrt_cnt_w(DEF_ITER);

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: bring down two radicand bits,
// try subtracting (root<<2)|1, and append the resulting root bit.
module sqrt_step #(
    parameter int ITER = 12
) (
    input  logic [ITER+1:0] rem,
    input  logic [ITER-1:0] root,
    input  logic [1:0]      bits,
    output logic [ITER+1:0] rem_next,
    output logic [ITER-1:0] root_next
);

    logic [ITER+1:0] rem_shift;
    logic [ITER+1:0] trial;
    logic            take;

    always_comb begin
        rem_shift = (rem << 2) | (ITER + 2)'(bits);
        trial     = {root, 2'b01};
        take      = (rem_shift >= trial);
        rem_next  = take ? (rem_shift - trial) : rem_shift;
        root_next = (root << 1) | ITER'(take);
    end

endmodule

// File: rtl/square_root_seq.sv
// Sequential fixed-point square root, one result bit per clock, valid/ready on both sides.
// Define SQRT_ROUND_EN for a round-half-up result (one extra guard iteration).
module square_root_seq
    import sqrt_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = sqrt_out_w(IN_W, FRAC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             busy
);

    localparam int ITER  = sqrt_iter(IN_W, FRAC_W);
    localparam int RAD_W = 2 * ITER;
    localparam int REM_W = ITER + 2;
    localparam int CNT_W = sqrt_cnt_w(ITER);
    // Aligns the integer part so the radicand fills exactly RAD_W bits.
    localparam int SHIFT = 2 * (ITER - (IN_W + 1) / 2);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [RAD_W-1:0]   rad_reg;
    logic [REM_W-1:0]   rem_reg;
    logic [ITER-1:0]    root_reg;
    logic [OUT_W-1:0]   out_reg;

    logic [REM_W-1:0]   rem_step;
    logic [ITER-1:0]    root_step;
    logic [OUT_W-1:0]   out_final;

    sqrt_step #(
        .ITER (ITER)
    ) u_step (
        .rem       (rem_reg),
        .root      (root_reg),
        .bits      (rad_reg[RAD_W-1 -: 2]),
        .rem_next  (rem_step),
        .root_next (root_step)
    );

`ifdef SQRT_ROUND_EN
    logic [OUT_W:0] rounded;

    always_comb begin
        rounded   = {1'b0, root_step[ITER-1:1]} + (OUT_W + 1)'(root_step[0]);
        out_final = rounded[OUT_W] ? '1 : rounded[OUT_W-1:0];
    end
`else
    assign out_final = root_step;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            rad_reg  <= '0;
            rem_reg  <= '0;
            root_reg <= '0;
            out_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        rad_reg  <= RAD_W'(in) << SHIFT;
                        rem_reg  <= '0;
                        root_reg <= '0;
                        cnt_reg  <= CNT_W'(ITER - 1);
                    end
                end
                CALC: begin
                    rad_reg  <= rad_reg << 2;
                    rem_reg  <= rem_step;
                    root_reg <= root_step;
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0) begin
                        out_reg <= out_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_square_root_seq.sv
// Bench for square_root_seq: default 8.8 instance plus a 16-bit integer instance.
// Expected values follow SQRT_ROUND_EN when the bench is built with it.
module tb_square_root_seq;

    localparam int OUT_W = 12;
`ifdef SQRT_ROUND_EN
    localparam int ITER   = 13;
    localparam int ITER16 = 9;
`else
    localparam int ITER   = 12;
    localparam int ITER16 = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_val;
    logic        busy;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] in16 = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b0;
    logic [7:0]  out16;
    logic        busy16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    square_root_seq #(.IN_W(8), .FRAC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_val),
        .busy      (busy)
    );

    square_root_seq #(.IN_W(16), .FRAC_W(0)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in        (in16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out       (out16),
        .busy      (busy16)
    );

    function automatic longint isqrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // floor(sqrt(x * 4^frac)), or that value rounded half-up and saturated.
    function automatic longint ref_sqrt(input longint x, input int in_w, input int frac_w);
        int     ow = (in_w + 1) / 2 + frac_w;
        longint r;
`ifdef SQRT_ROUND_EN
        r = isqrt(x * (longint'(1) << (2 * frac_w + 2)));
        r = (r >> 1) + (r & 1);
        if (r >= (longint'(1) << ow)) r = (longint'(1) << ow) - 1;
`else
        r = isqrt(x * (longint'(1) << (2 * frac_w)));
`endif
        return r;
    endfunction

    // Offers v, then counts edges after the accepting edge until out_valid.
    task automatic start_op(input logic [7:0] v, output int lat);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_val   = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_val   = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_val !== 12'h000) begin errors++; $display("FAIL reset_out: got %h expected 000", out_val); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
            errors++; $display("FAIL reset_dut16: in_ready=%b out_valid=%b expected 1/0", in_ready16, out_valid16);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: in_ready=%b out_valid=%b out=%h busy=%b", in_ready, out_valid, out_val, busy);
    endtask

    task automatic test_vectors();
        logic [7:0]  vin [6] = '{8'd16, 8'd2, 8'd3, 8'd1, 8'd0, 8'd255};
`ifdef SQRT_ROUND_EN
        logic [11:0] vexp [6] = '{12'h400, 12'h16A, 12'h1BB, 12'h100, 12'h000, 12'hFF8};
`else
        logic [11:0] vexp [6] = '{12'h400, 12'h16A, 12'h1BB, 12'h100, 12'h000, 12'hFF7};
`endif
        int          lat;
        logic [11:0] res;
        for (int i = 0; i < 6; i++) begin
            start_op(vin[i], lat);
            res = out_val;
            checks++;
            if (res !== vexp[i]) begin
                errors++; $display("FAIL vector_out in=%0d: got %h expected %h", vin[i], res, vexp[i]);
            end
            // Edges counted including the accepting edge.
            checks++;
            if (lat + 1 != ITER + 1) begin
                errors++; $display("FAIL vector_latency in=%0d: got %0d edges expected %0d", vin[i], lat + 1, ITER + 1);
            end
            take_result();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_val !== res) begin
                errors++;
                $display("FAIL vector_release in=%0d: out_valid=%b in_ready=%b out=%h expected 0/1/%h",
                         vin[i], out_valid, in_ready, out_val, res);
            end
            $display("vector: in=%0d out=%h latency=%0d", vin[i], res, lat + 1);
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [7:0]  v;
        logic [11:0] exp_out;
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            exp_out = 12'(ref_sqrt(longint'(v), 8, 8));
            start_op(v, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (out_val !== exp_out || out_valid !== 1'b1) begin
                errors++; $display("FAIL random_out in=%0d: got %h valid=%b expected %h", v, out_val, out_valid, exp_out);
            end
            $display("random: in=%0d out=%h", v, out_val);
            take_result();
        end
    endtask

    task automatic test_hold();
        int          guard = 0;
        logic [11:0] held;
        logic [11:0] exp_out = 12'(ref_sqrt(longint'(8'd255), 8, 8));
        in_valid = 1'b1;
        in_val   = 8'd255;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_busy: busy=%b in_ready=%b expected 1/0", busy, in_ready);
        end
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        held = out_val;
        checks++;
        if (held !== exp_out) begin errors++; $display("FAIL hold_value: got %h expected %h", held, exp_out); end
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_val   = 8'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_val !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: out_valid=%b out=%h in_ready=%b expected 1/%h/0",
                         c, out_valid, out_val, in_ready, held);
            end
        end
        in_valid = 1'b0;
        take_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        guard = 0;
        for (int c = 0; c < ITER + 4; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) guard++;
        end
        checks++;
        if (guard != 0) begin errors++; $display("FAIL hold_no_ghost: got %0d bad cycles expected 0", guard); end
        $display("hold: out=%h held 20 cycles", held);
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        in_valid = 1'b1;
        in_val   = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_val !== 12'h000) begin
            errors++;
            $display("FAIL midreset_state: in_ready=%b out_valid=%b busy=%b out=%h expected 1/0/0/000",
                     in_ready, out_valid, busy, out_val);
        end
        for (int c = 0; c < ITER + 4; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_abandon: got %0d valid cycles expected 0", seen); end
        start_op(8'd16, lat);
        checks++;
        if (out_val !== 12'h400 || lat != ITER) begin
            errors++; $display("FAIL midreset_next: got %h lat=%0d expected 400 lat=%0d", out_val, lat, ITER);
        end
        $display("midreset: next in=16 out=%h", out_val);
        take_result();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pending [$];
        logic [15:0] v;
        logic [7:0]  exp_out;
        int          results = 0;
        int          last_cyc = -1;
        bit          change = 1'b0;
        in16        = 16'hFFFF;
        in_valid16  = 1'b1;
        out_ready16 = 1'b1;
        for (int cyc = 0; cyc < 200 && results < 5; cyc++) begin
            if (change) begin
                in16   = 16'($urandom);
                change = 1'b0;
            end
            if (in_ready16) begin
                pending.push_back(in16);
                change = 1'b1;
            end
            if (out_valid16) begin
                if (pending.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_unexpected: got result %0d expected none", out16);
                end else begin
                    v = pending.pop_front();
                    exp_out = 8'(ref_sqrt(longint'(v), 16, 0));
                    checks++;
                    if (out16 !== exp_out || (results == 0 && out16 !== 8'd255)) begin
                        errors++; $display("FAIL b2b_out in=%0d: got %0d expected %0d", v, out16, exp_out);
                    end
                    if (last_cyc >= 0) begin
                        checks++;
                        if (cyc - last_cyc != ITER16 + 2) begin
                            errors++; $display("FAIL b2b_period: got %0d cycles expected %0d", cyc - last_cyc, ITER16 + 2);
                        end
                    end
                    $display("b2b: in=%0d out=%0d cycle=%0d", v, out16, cyc);
                end
                last_cyc = cyc;
                results++;
            end
            @(negedge clk);
        end
        in_valid16  = 1'b0;
        checks++;
        if (results != 5) begin errors++; $display("FAIL b2b_count: got %0d results expected 5", results); end
        repeat (ITER16 + 4) @(negedge clk);
        out_ready16 = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_vectors();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
